// File: rtl/sbox_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : sbox_table_loader
// Purpose  : Writer side of the substitution layer's LUT update port. Collects
//            a complete 32-entry x 5-bit S-box table from the configuration
//            stream into a shadow copy. It waits until the permutation datapath
//            is idle. It then writes the table into the sub_layer LUT bank at
//            one entry per cycle.
// Optional : SBOX_LOADER_CHECK_EN - reject tables that are not a bijection
//            (seen-mask check). When the macro is undefined, err_o is tied to 0.
// Ports    :
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   load_req_i       single-cycle request to start (or restart) a table load
//   word_valid_i     configuration word valid
//   word_ready_o     configuration word accepted when high with word_valid_i
//   word_i           four packed entries, entry k at word_i[5k+4:5k]
//   perm_busy_i      permutation datapath is using the S-boxes
//   upd_sbox_o       LUT update strobe (registered)
//   sbox_new_data_o  {index[4:0], 11'b0, value[4:0]}, zero when no strobe
//   busy_o           loader is in any state other than IDLE
//   done_o           one-cycle pulse after the final update
//   err_o            last collected table was rejected
// Revision : 1.0 - initial release
// ============================================================================
module sbox_table_loader #(
    parameter int ENTRIES = 32,
    parameter int ENTRY_W = 5,
    parameter int EPW     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_req_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    input  logic [EPW*ENTRY_W-1:0]   word_i,
    input  logic                     perm_busy_i,
    output logic                     upd_sbox_o,
    output logic [20:0]              sbox_new_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PROGRAM = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [2:0]         wcnt_q,  wcnt_d;
    logic [4:0]         idx_q,   idx_d;
    logic               upd_q,   upd_d;
    logic [20:0]        data_q,  data_d;
    logic               done_q,  done_d;
    logic [ENTRY_W-1:0] shadow_q [ENTRIES];

    // Restart has priority: a word presented in the same cycle as load_req_i
    // is dropped and never reaches the shadow.
    logic wr_word;
    logic table_ok;
    assign wr_word = (state_q == S_COLLECT) && word_valid_i && !load_req_i;

`ifdef SBOX_LOADER_CHECK_EN
    logic [ENTRIES-1:0] mask_q, mask_d, mask_word;
    logic               err_q,  err_d;

    // One-hot of the four values carried by the word being accepted.
    always_comb begin
        mask_word = '0;
        for (int k = 0; k < EPW; k++) begin
            mask_word[word_i[k*ENTRY_W +: ENTRY_W]] = 1'b1;
        end
    end

    // Includes the current word so the verdict is ready on the final handshake.
    assign table_ok = &(mask_q | mask_word);

    always_comb begin
        mask_d = mask_q;
        if (load_req_i && (state_q == S_IDLE || state_q == S_COLLECT)) begin
            mask_d = '0;
        end else if (wr_word) begin
            mask_d = mask_q | mask_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign table_ok = 1'b1;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        upd_d   = 1'b0;
        data_d  = '0;
        done_d  = 1'b0;
`ifdef SBOX_LOADER_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
                    state_d = S_COLLECT;
                    wcnt_d  = '0;
`ifdef SBOX_LOADER_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_COLLECT: begin
                if (load_req_i) begin
                    wcnt_d = '0;
                end else if (word_valid_i) begin
                    wcnt_d = wcnt_q + 3'd1;
                    if (wcnt_q == 3'd7) begin
                        if (table_ok) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_IDLE;
`ifdef SBOX_LOADER_CHECK_EN
                            err_d   = 1'b1;
`endif
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!perm_busy_i) begin
                    state_d = S_PROGRAM;
                    idx_d   = '0;
                end
            end
            S_PROGRAM: begin
                upd_d  = 1'b1;
                data_d = {idx_q, 11'b0, shadow_q[idx_q]};
                idx_d  = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            upd_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            upd_q   <= upd_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (wr_word) begin
                for (int k = 0; k < EPW; k++) begin
                    shadow_q[{wcnt_q, 2'(k)}] <= word_i[k*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    assign word_ready_o    = (state_q == S_COLLECT);
    assign busy_o          = (state_q != S_IDLE);
    assign upd_sbox_o      = upd_q;
    assign sbox_new_data_o = data_q;
    assign done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_table_loader
// Purpose  : Self-checking bench for sbox_table_loader. It uses a table of
//            load records (table contents, perm_busy hold, restart point and
//            expected strobe count and error). It also includes hand-written
//            sequences for the reset-during-programming case and for the Ascon
//            reference values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_table_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req_i = 1'b0;
    logic        word_valid_i = 1'b0;
    logic [19:0] word_i = '0;
    logic        perm_busy_i = 1'b0;
    logic        word_ready_o, upd_sbox_o, busy_o, done_o, err_o;
    logic [20:0] sbox_new_data_o;

    sbox_table_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_req_i      (load_req_i),
        .word_valid_i    (word_valid_i),
        .word_ready_o    (word_ready_o),
        .word_i          (word_i),
        .perm_busy_i     (perm_busy_i),
        .upd_sbox_o      (upd_sbox_o),
        .sbox_new_data_o (sbox_new_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / done observer, sampled on the falling edge.
    logic [20:0] s_data [$];
    int          s_cyc  [$];
    int          done_cyc [$];
    int          idle_bad = 0;
    always @(negedge clk) begin
        if (upd_sbox_o) begin
            s_data.push_back(sbox_new_data_o);
            s_cyc.push_back(cyc);
        end else if (sbox_new_data_o != 21'd0) begin
            idle_bad++;
        end
        if (done_o) done_cyc.push_back(cyc);
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [159:0] tbl;
        int           hold;     // perm_busy_i cycles held high after the 8th word
        int           restart;  // junk words before a restart (0 = none)
        int           exp_n;    // expected strobe count
        logic         exp_err;
    } vec_t;

    logic [159:0] id_t, rev_t, asc_t, dup_t;
    logic [4:0]   asc [32];
    vec_t         vecs [5];

    function automatic logic [19:0] word_of(input logic [159:0] t, input int w);
        return t[w*20 +: 20];
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int t;
        int busy_bad;
        int k;
        logic [20:0] exp_d;
        busy_bad = 0;
        s_data.delete(); s_cyc.delete(); done_cyc.delete();
        @(negedge clk); load_req_i = 1'b1;
        @(negedge clk); load_req_i = 1'b0;
        check({nm, " ready_in_collect"}, {31'd0, word_ready_o}, 32'd1);
        if (v.restart > 0) begin
            for (int w = 0; w < v.restart; w++) begin
                word_valid_i = 1'b1; word_i = word_of(asc_t, w);
                @(negedge clk);
            end
            // Restart coincides with a handshake: that word must be dropped.
            load_req_i = 1'b1; word_i = word_of(asc_t, v.restart);
            @(negedge clk); load_req_i = 1'b0;
        end
        perm_busy_i = (v.hold > 0);
        for (int w = 0; w < 8; w++) begin
            word_valid_i = 1'b1; word_i = word_of(v.tbl, w);
            @(negedge clk);
        end
        word_valid_i = 1'b0;
        t = cyc;
        check({nm, " ready_after_8th"}, {31'd0, word_ready_o}, 32'd0);
        check({nm, " busy_after_8th"}, {31'd0, busy_o}, (v.exp_n != 0) ? 32'd1 : 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            if (!busy_o) busy_bad++;
            @(negedge clk);
        end
        perm_busy_i = 1'b0;
        k = 0;
        while (k < 60 && done_cyc.size() == 0) begin
            @(negedge clk); k++;
        end
        check({nm, " strobe_count"}, s_data.size(), v.exp_n);
        check({nm, " busy_during_hold"}, busy_bad, 0);
        if (v.exp_n == 32 && s_data.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                exp_d = {5'(i), 11'b0, v.tbl[i*5 +: 5]};
                check($sformatf("%s strobe%0d", nm, i), s_data[i], exp_d);
            end
            check({nm, " first_strobe_cyc"}, s_cyc[0] - t, v.hold + 2);
            check({nm, " last_strobe_cyc"}, s_cyc[31] - t, v.hold + 33);
            check({nm, " done_count"}, done_cyc.size(), 1);
            if (done_cyc.size() == 1) check({nm, " done_cyc"}, done_cyc[0] - t, v.hold + 34);
        end else begin
            check({nm, " no_done"}, done_cyc.size(), 0);
        end
        check({nm, " err"}, {31'd0, err_o}, {31'd0, v.exp_err});
        check({nm, " busy_end"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int k;
        asc = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        for (int i = 0; i < 32; i++) begin
            id_t[i*5 +: 5]  = 5'(i);
            rev_t[i*5 +: 5] = 5'(31 - i);
            asc_t[i*5 +: 5] = asc[i];
        end
        dup_t = id_t;
        dup_t[4:0] = 5'h07;
        dup_t[9:5] = 5'h07;

        vecs[0] = '{tbl: id_t,  hold: 0,  restart: 0, exp_n: 32, exp_err: 1'b0};
        vecs[1] = '{tbl: asc_t, hold: 0,  restart: 0, exp_n: 32, exp_err: 1'b0};
`ifdef SBOX_LOADER_CHECK_EN
        vecs[2] = '{tbl: dup_t, hold: 0,  restart: 0, exp_n: 0,  exp_err: 1'b1};
`else
        vecs[2] = '{tbl: dup_t, hold: 0,  restart: 0, exp_n: 32, exp_err: 1'b0};
`endif
        vecs[3] = '{tbl: asc_t, hold: 20, restart: 0, exp_n: 32, exp_err: 1'b0};
        vecs[4] = '{tbl: rev_t, hold: 0,  restart: 5, exp_n: 32, exp_err: 1'b0};

        // Reset state
        #1;
        check("rst ready", {31'd0, word_ready_o}, 32'd0);
        check("rst upd",   {31'd0, upd_sbox_o}, 32'd0);
        check("rst data",  {11'd0, sbox_new_data_o}, 32'd0);
        check("rst busy",  {31'd0, busy_o}, 32'd0);
        check("rst done",  {31'd0, done_o}, 32'd0);
        check("rst err",   {31'd0, err_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Ascon reference values, hand-computed.
        run_vec(vecs[1], "asc2");
        if (s_data.size() == 32) begin
            check("asc strobe0",  s_data[0],  21'h00004);
            check("asc strobe3",  s_data[3],  21'h30014);
            check("asc strobe31", s_data[31], 21'h1F0017);
        end

        // Reset mid-PROGRAM after strobe 10.
        s_data.delete(); s_cyc.delete(); done_cyc.delete();
        @(negedge clk); load_req_i = 1'b1;
        @(negedge clk); load_req_i = 1'b0;
        for (int w = 0; w < 8; w++) begin
            word_valid_i = 1'b1; word_i = word_of(id_t, w);
            @(negedge clk);
        end
        word_valid_i = 1'b0;
        k = 0;
        while (k < 40 && s_data.size() < 11) begin
            @(negedge clk); k++;
        end
        check("midrst reached strobe10", (s_data.size() >= 11) ? 32'd1 : 32'd0, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst upd",  {31'd0, upd_sbox_o}, 32'd0);
        check("midrst data", {11'd0, sbox_new_data_o}, 32'd0);
        check("midrst busy", {31'd0, busy_o}, 32'd0);
        check("midrst done", {31'd0, done_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_vec(vecs[0], "after_rst");

        check("data zero without strobe", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_table_loader.md
Name: sbox_table_loader

Overview:
- Writer side of the substitution layer's LUT update port.
- Collects a full 32-entry, 5-bit S-box table from a configuration stream and holds it in a 160-bit shadow.
- Waits until the permutation datapath is idle, then drives one update per cycle onto upd_sbox / sbox_new_data into the sub_layer LUT bank.
- Sits between the accelerator's config register block and the sub_layer.

Parameters:
- ENTRIES, 32, number of S-box table entries; fixed by the 5-bit address.
- ENTRY_W, 5, bits per table entry.
- EPW, 4, entries packed per configuration word.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- load_req_i  input  1  single-cycle request to start a new table load.
- word_valid_i  input  1  config word valid.
- word_ready_o  output  1  config word accepted when high together with word_valid_i.
- word_i  input  20  four entries; entry k of the word is word_i[5k+4:5k].
- perm_busy_i  input  1  permutation datapath is currently using the S-boxes.
- upd_sbox_o  output  1  update strobe to the sub_layer.
- sbox_new_data_o  output  21  update word: [20:16] entry index, [15:5] zero, [4:0] entry value.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse after the last update.
- err_o  output  1  table rejected (see Optional Feature).

Behaviour:
- Reset state:
  - state = IDLE.
  - Shadow, word counter (3 bits) and index counter (5 bits) = 0.
  - All outputs = 0.
- FSM states: IDLE, COLLECT, WAIT, PROGRAM, DONE.
- IDLE:
  - word_ready_o = 0.
  - load_req_i moves to COLLECT and clears the word counter and the err_o flag.
- COLLECT:
  - word_ready_o = 1.
  - Each handshake writes word_i into shadow entries 4w..4w+3 and increments w.
  - The handshake that accepts word 7 moves to WAIT; word_ready_o drops the next cycle.
  - load_req_i in COLLECT restarts the load: w = 0 and earlier words are discarded. If load_req_i and a handshake coincide, the restart wins and the word is dropped.
- WAIT:
  - Stays in WAIT while perm_busy_i = 1.
  - When perm_busy_i = 0, moves to PROGRAM with idx = 0.
  - perm_busy_i is sampled only in WAIT.
- PROGRAM:
  - upd_sbox_o = 1 every cycle.
  - sbox_new_data_o = {idx, 11'b0, shadow[idx]}; idx increments each cycle.
  - After idx = 31 moves to DONE. Exactly 32 back-to-back strobes, indices 0..31 in order.
  - load_req_i and perm_busy_i are ignored. The top level must gate permutation start on busy_o.
- DONE: done_o = 1 for one cycle, then IDLE.
- upd_sbox_o and sbox_new_data_o are registered. sbox_new_data_o = 0 whenever upd_sbox_o = 0.
- Latency, with the 8th word accepted at edge t and perm_busy_i = 0:
  - WAIT at t+1.
  - First strobe at t+2, last strobe at t+33.
  - done_o at t+34.
- rst_n asserted mid-operation returns immediately to IDLE with outputs 0. A partially programmed LUT is not restored; software reloads it.
- Shadow contents persist in IDLE and are overwritten only by new accepted words.

Optional Feature:
- Macro: SBOX_LOADER_CHECK_EN.
- When defined:
  - A 32-bit seen-mask is cleared on entry to COLLECT.
  - Each stored entry value v sets bit v.
  - On leaving COLLECT, a mask that is not all ones (the table is not a bijection) sends the FSM to IDLE instead of WAIT. No strobes are issued.
  - err_o is set and stays set until the next load_req_i.
  - A valid table leaves err_o = 0.
- When not defined: no mask logic, err_o tied to 0, and every collected table is programmed.

Test Plan:
- Reset mid-PROGRAM (pull rst_n low after strobe 10) -> all outputs 0 asynchronously, state IDLE; a fresh load then completes normally.
- Identity table (words 0x18820, 0x398A4, ... entry i = i), perm_busy_i = 0 -> 32 strobes with sbox_new_data_o = {i, 11'b0, i}, first at t+2, done_o at t+34.
- Ascon table, first word 0xA7D64 (entries 0x04, 0x0B, 0x1F, 0x14) -> strobe 0 data = 0x00004, strobe 3 data = 0x30014; index 31 carries the table's last entry.
- perm_busy_i held high 20 cycles after the 8th word -> no strobe during the hold; the first strobe comes 1 cycle after perm_busy_i falls; busy_o stays high throughout.
- load_req_i after 5 accepted words, then 8 new words -> only the new words are programmed; 32 strobes total.
- With SBOX_LOADER_CHECK_EN, a table with entries 0 and 1 both = 0x07 -> zero strobes, err_o = 1 until the next load_req_i, done_o never pulses.
